// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter: register map, CTRL bit layout
// and register reset values.
package up_down_counter_pkg;
  localparam int DATA_W = 8;
  localparam int CTRL_W = 2;

  typedef enum logic [1:0] {
    ADDR_LOAD = 2'd0,
    ADDR_LOW  = 2'd1,
    ADDR_HIGH = 2'd2,
    ADDR_CTRL = 2'd3
  } addr_e;

  localparam int CTRL_DIR_BIT  = 0;
  localparam int CTRL_MODE_BIT = 1;

  localparam logic [DATA_W-1:0] LOAD_DEFAULT = 8'h00;
  localparam logic [DATA_W-1:0] LOW_DEFAULT  = 8'h00;
  localparam logic [DATA_W-1:0] HIGH_DEFAULT = 8'hFF;
  localparam logic [CTRL_W-1:0] CTRL_DEFAULT = 2'b01;
endpackage

// File: rtl/up_down_counter_regs.sv
// Register file and bus decode: LOAD/LOW/HIGH/CTRL storage, readback mux,
// and detection of simultaneous read/write strobes.
module up_down_counter_regs
  import up_down_counter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              ncs,
  input  logic              nrd,
  input  logic              nwr,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] low_val,
  output logic [DATA_W-1:0] high_val,
  output logic [CTRL_W-1:0] ctrl_val,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic              conflict
);

  logic  wr_en;
  addr_e sel;

  assign sel      = addr_e'(addr);
  assign wr_en    = ~ncs & ~nwr & nrd;
  assign rd_en    = ~ncs & ~nrd & nwr;
  assign conflict = ~ncs & ~nwr & ~nrd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      load_val <= LOAD_DEFAULT;
      low_val  <= LOW_DEFAULT;
      high_val <= HIGH_DEFAULT;
      ctrl_val <= CTRL_DEFAULT;
    end else if (wr_en) begin
      case (sel)
        ADDR_LOAD: load_val <= din;
        ADDR_LOW:  low_val  <= din;
        ADDR_HIGH: high_val <= din;
        ADDR_CTRL: ctrl_val <= din[CTRL_W-1:0];
        default:   ;
      endcase
    end
  end

  // Reserved CTRL bits read back as zero.
  always_comb begin
    rd_data = '0;
    case (sel)
      ADDR_LOAD: rd_data = load_val;
      ADDR_LOW:  rd_data = low_val;
      ADDR_HIGH: rd_data = high_val;
      ADDR_CTRL: rd_data = {{(DATA_W-CTRL_W){1'b0}}, ctrl_val};
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: rtl/up_down_counter.sv
// Bounded up/down counter with bus-programmable start value, limits and
// one-shot/bounce mode; register readback shares the count output.
module up_down_counter
  import up_down_counter_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic              clk,
  input  logic              ncs,
  input  logic              nrd,
  input  logic              nwr,
  input  logic              start,
  input  logic              reset,
  input  logic              A0,
  input  logic              A1,
  output logic [DATA_W-1:0] count,
  output logic              err,
  output logic              ec,
  output logic              dir
);

  logic [DATA_W-1:0] load_val, low_val, high_val, rd_data, cnt;
  logic [CTRL_W-1:0] ctrl_val;
  logic              rd_en, conflict, running, start_q, start_edge, at_limit;

  up_down_counter_regs u_regs (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .ncs      (ncs),
    .nrd      (nrd),
    .nwr      (nwr),
    .addr     ({A1, A0}),
    .load_val (load_val),
    .low_val  (low_val),
    .high_val (high_val),
    .ctrl_val (ctrl_val),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .conflict (conflict)
  );

  // One step toward the requested direction, saturating at the active limit.
  function automatic logic [DATA_W-1:0] step_sat(
    input logic [DATA_W-1:0] val,
    input logic              up,
    input logic [DATA_W-1:0] lo,
    input logic [DATA_W-1:0] hi
  );
    if (up) return (val < hi) ? val + DATA_W'(1) : val;
    else    return (val > lo) ? val - DATA_W'(1) : val;
  endfunction

  assign start_edge = start & ~start_q;
  assign at_limit   = dir ? (cnt >= high_val) : (cnt <= low_val);
  assign count      = rd_en ? rd_data : cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      dir     <= 1'b1;
      running <= 1'b0;
      err     <= 1'b0;
      ec      <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      ec      <= 1'b0;
      if (start_edge) begin
        if ((low_val <= load_val) && (load_val <= high_val)) begin
          cnt     <= load_val;
          dir     <= ctrl_val[CTRL_DIR_BIT];
          running <= 1'b1;
          err     <= 1'b0;
        end else begin
          err     <= 1'b1;
          running <= 1'b0;
        end
      end else if (running && start) begin
        if (at_limit) begin
          ec <= 1'b1;
          if (ctrl_val[CTRL_MODE_BIT]) begin
            dir <= ~dir;
            cnt <= step_sat(cnt, ~dir, low_val, high_val);
          end else begin
            running <= 1'b0;
          end
        end else begin
          cnt <= step_sat(cnt, dir, low_val, high_val);
        end
      end
      // A read/write strobe collision always flags, even on a valid start edge.
      if (conflict) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed-vector bench for up_down_counter with hand-computed expectations.
module tb_up_down_counter;
  logic [7:0] din;
  logic       clk, ncs, nrd, nwr, start, reset, A0, A1;
  logic [7:0] count;
  logic       err, ec, dir;
  logic [7:0] rv;
  int         n_tests = 0;
  int         n_fail  = 0;

  up_down_counter dut (
    .din   (din),
    .clk   (clk),
    .ncs   (ncs),
    .nrd   (nrd),
    .nwr   (nwr),
    .start (start),
    .reset (reset),
    .A0    (A0),
    .A1    (A1),
    .count (count),
    .err   (err),
    .ec    (ec),
    .dir   (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    {A1, A0} = a;
    din = d;
    ncs = 1'b0; nwr = 1'b0; nrd = 1'b1;
    tick();
    ncs = 1'b1; nwr = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    {A1, A0} = a;
    ncs = 1'b0; nrd = 1'b0; nwr = 1'b1;
    #1;
    d = count;
    ncs = 1'b1; nrd = 1'b1;
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] c, input logic d, input logic e);
    check_eq({tag, ".count"}, count, c);
    check_eq({tag, ".dir"}, {7'd0, dir}, {7'd0, d});
    check_eq({tag, ".ec"}, {7'd0, ec}, {7'd0, e});
  endtask

  task automatic chk_defaults(input string tag);
    rd(2'd0, rv); check_eq({tag, ".load"}, rv, 8'h00);
    rd(2'd1, rv); check_eq({tag, ".low"},  rv, 8'h00);
    rd(2'd2, rv); check_eq({tag, ".high"}, rv, 8'hFF);
    rd(2'd3, rv); check_eq({tag, ".ctrl"}, rv, 8'h01);
  endtask

  initial begin
    din = 8'h00; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1;
    start = 1'b0; reset = 1'b0; A0 = 1'b0; A1 = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Reset state and register defaults
    chk_defaults("rst");
    chk_state("rst", 8'h00, 1'b1, 1'b0);
    check_eq("rst.err", {7'd0, err}, 8'd0);

    // Bounce mode, starting downward at LOW
    wr(2'd0, 8'd10); wr(2'd1, 8'd10); wr(2'd2, 8'd15); wr(2'd3, 8'd2);
    start = 1'b1;
    tick(); chk_state("bnc0", 8'd10, 1'b0, 1'b0);
    tick(); chk_state("bnc1", 8'd11, 1'b1, 1'b1);
    tick(); chk_state("bnc2", 8'd12, 1'b1, 1'b0);
    tick(); chk_state("bnc3", 8'd13, 1'b1, 1'b0);
    tick(); chk_state("bnc4", 8'd14, 1'b1, 1'b0);
    tick(); chk_state("bnc5", 8'd15, 1'b1, 1'b0);
    tick(); chk_state("bnc6", 8'd14, 1'b0, 1'b1);
    start = 1'b0;
    tick(); chk_state("pause", 8'd14, 1'b0, 1'b0);
    tick(); chk_state("pause2", 8'd14, 1'b0, 1'b0);

    // One-shot up from 13
    wr(2'd3, 8'd1); wr(2'd0, 8'd13);
    start = 1'b1;
    tick(); chk_state("os0", 8'd13, 1'b1, 1'b0);
    tick(); chk_state("os1", 8'd14, 1'b1, 1'b0);
    tick(); chk_state("os2", 8'd15, 1'b1, 1'b0);
    tick(); chk_state("os3", 8'd15, 1'b1, 1'b1);
    tick(); chk_state("os4", 8'd15, 1'b1, 1'b0);
    tick(); chk_state("os5", 8'd15, 1'b1, 1'b0);
    start = 1'b0;
    tick();

    // Invalid LOAD above HIGH, then recovery
    wr(2'd0, 8'd20);
    start = 1'b1;
    tick();
    check_eq("inv.err", {7'd0, err}, 8'd1);
    check_eq("inv.count", count, 8'd15);
    tick();
    check_eq("inv.hold", count, 8'd15);
    start = 1'b0;
    tick();
    wr(2'd0, 8'd12);
    start = 1'b1;
    tick();
    check_eq("rec.err", {7'd0, err}, 8'd0);
    check_eq("rec.count", count, 8'd12);
    start = 1'b0;
    tick();

    // Strobe collision and deselected write
    {A1, A0} = 2'd0; din = 8'h55;
    ncs = 1'b0; nwr = 1'b0; nrd = 1'b0;
    tick();
    ncs = 1'b1; nwr = 1'b1; nrd = 1'b1;
    check_eq("col.err", {7'd0, err}, 8'd1);
    rd(2'd0, rv); check_eq("col.load", rv, 8'd12);
    {A1, A0} = 2'd1; din = 8'h77;
    ncs = 1'b1; nwr = 1'b0;
    tick();
    nwr = 1'b1;
    rd(2'd1, rv); check_eq("ncs.low", rv, 8'd10);
    check_eq("col.sticky", {7'd0, err}, 8'd1);

    // LOW == HIGH in bounce mode
    wr(2'd1, 8'd12); wr(2'd2, 8'd12); wr(2'd0, 8'd12); wr(2'd3, 8'd3);
    start = 1'b1;
    tick(); chk_state("eq0", 8'd12, 1'b1, 1'b0);
    check_eq("eq.err", {7'd0, err}, 8'd0);
    tick(); chk_state("eq1", 8'd12, 1'b0, 1'b1);
    tick(); chk_state("eq2", 8'd12, 1'b1, 1'b1);
    start = 1'b0;
    tick(); chk_state("eq3", 8'd12, 1'b1, 1'b0);

    // Reset mid-run in bounce mode
    wr(2'd1, 8'd10); wr(2'd2, 8'd15); wr(2'd0, 8'd10); wr(2'd3, 8'd2);
    start = 1'b1;
    tick(); chk_state("mr0", 8'd10, 1'b0, 1'b0);
    tick(); chk_state("mr1", 8'd11, 1'b1, 1'b1);
    tick(); chk_state("mr2", 8'd12, 1'b1, 1'b0);
    reset = 1'b0;
    tick(); chk_state("mrst", 8'h00, 1'b1, 1'b0);
    check_eq("mrst.err", {7'd0, err}, 8'd0);
    start = 1'b0;
    reset = 1'b1;
    chk_defaults("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 SHALL use one clock and a synchronous active-low reset: clk in, reset in (active low, sampled on rising clk).
REQ-002 Ports SHALL be, in order:
- din, input, 8 bits: write data.
- clk, input, 1 bit: clock.
- ncs, input, 1 bit: chip select, active low.
- nrd, input, 1 bit: read strobe, active low.
- nwr, input, 1 bit: write strobe, active low.
- start, input, 1 bit: run enable, level.
- reset, input, 1 bit: synchronous reset, active low.
- A0, input, 1 bit: address LSB.
- A1, input, 1 bit: address MSB.
- count, output, 8 bits: counter value or register readback.
- err, output, 1 bit: error flag.
- ec, output, 1 bit: end-count pulse.
- dir, output, 1 bit: current direction, 1 = up.
REQ-003 Address {A1,A0} SHALL map registers as follows:
- 0 = LOAD, default 0x00: start value.
- 1 = LOW, default 0x00: lower limit.
- 2 = HIGH, default 0xFF: upper limit.
- 3 = CTRL, default 0x01: bit0 = initial direction (1 = up); bit1 = mode (0 = one-shot, 1 = bounce); bits 7:2 reserved, read as 0.

Function
REQ-004 A write SHALL occur on a rising clk when ncs=0, nwr=0 and nrd=1; din is stored into the addressed register.
REQ-005 When ncs=0, nrd=0 and nwr=1, count SHALL combinationally show the addressed register; otherwise count SHALL show the counter value.
REQ-006 ncs=0 with nwr=0 and nrd=0 together SHALL ignore the write and set err on the next edge.
REQ-007 On the first edge where start=1 after start=0 (registered start edge), the block SHALL validate LOW <= LOAD <= HIGH. If valid, the counter loads LOAD, dir takes CTRL[0], running is set and err is cleared. If invalid, err is set and running is cleared.
REQ-008 While running and start=1, each later edge SHALL step the counter by 1 in direction dir, using 8-bit arithmetic with no wrap past the limits.
REQ-009 At the limit in the current direction (dir=1 and count==HIGH, or dir=0 and count==LOW), the next edge SHALL pulse ec high for exactly one cycle. Then:
- One-shot mode: counter holds and running clears.
- Bounce mode: dir inverts and the counter steps one in the new direction.
REQ-010 With start=0 the counter, dir and running SHALL hold; ec SHALL be 0.
REQ-011 LOW==HIGH in bounce mode SHALL hold the counter and toggle dir, with an ec pulse every cycle.
REQ-012 Register writes during a run SHALL take effect as follows: LOW and HIGH at once, for comparison; LOAD and CTRL[0] only at the next start edge; CTRL[1] at once.
REQ-013 err SHALL be sticky until the next valid start edge or reset.

Reset
REQ-014 With reset=0 at a rising clk:
- Registers take their defaults.
- Counter = 0x00, running = 0, err = 0, ec = 0, dir = 1, start-edge detector cleared.
REQ-015 Reset SHALL take priority over writes and counting, including reset asserted mid-run.

Structure
REQ-016 A shared package up_down_counter_pkg SHALL hold:
- the address constants;
- the CTRL bit indices;
- the register reset defaults.
REQ-017 The register file and bus decode SHALL be one sub-module, up_down_counter_regs. The counter and control logic SHALL stay in the top module.

Verification
REQ-018 Reset, then read addresses 0-3 -> count = 0x00, 0x00, 0xFF, 0x01; err=0, ec=0, dir=1.
REQ-019 Write LOAD=10, LOW=10, HIGH=15, CTRL=2, then raise start -> count 10, dir=0. Then:
- count 11 with dir=1 and ec=1 for one cycle;
- count 12, 13, 14, 15;
- count 14 with dir=0 and ec=1.
REQ-020 Write CTRL=1, LOAD=13, LOW=10, HIGH=15, then raise start -> count 13, 14, 15, then hold 15; ec=1 for exactly one cycle; later cycles ec=0.
REQ-021 Write LOAD=20, LOW=10, HIGH=15, then raise start -> err=1 and count holds. Then write LOAD=12 and toggle start -> err=0 and count=12.
REQ-022 With ncs=0, drive nwr=0 and nrd=0 with A1A0=0 and din=0x55 -> LOAD unchanged and err=1. Also, ncs=1 with nwr=0 -> no write.
REQ-023 Assert reset=0 mid-run in bounce mode -> next edge count=0x00, dir=1, ec=0, and registers return to defaults.
